// File: rtl/cemf_sr_pkg.sv
// rtl/cemf_sr_pkg.sv - shared constants for the CEMF electrode shift-register loader
package cemf_sr_pkg;

    localparam int DEF_N_ELECTRODES = 128;
    localparam int DEF_CLK_DIV      = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_LATCH  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sr_tick_gen.sv
// rtl/sr_tick_gen.sv - CLK_DIV divider producing the half-period wrap tick and phase flag
module sr_tick_gen
    import cemf_sr_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic phase
);

    localparam int DIV_W = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = enable && (div_cnt == DIV_LAST);

    // phase 0 = sr_clk low half, phase 1 = sr_clk high half
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (clear) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (enable) begin
            if (tick) begin
                div_cnt <= '0;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/elec_sr_loader.sv
// rtl/elec_sr_loader.sv - serial loader for the external electrode shift-register chain
module elec_sr_loader
    import cemf_sr_pkg::*;
#(
    parameter int N_ELECTRODES = DEF_N_ELECTRODES,
    parameter int CLK_DIV      = DEF_CLK_DIV
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    enable_sr_out,
    input  logic [N_ELECTRODES-1:0] elec_config,
    output logic                    sr_clk,
    output logic                    sr_data,
    output logic                    sr_latch,
    output logic                    sr_busy,
    output logic                    sr_finish
);

    localparam int CNT_W = clog2(N_ELECTRODES);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(N_ELECTRODES - 1);

    logic [1:0]              state;
    logic                    req_d;
    // MSB goes straight to sr_data at capture, so the shadow only keeps the rest
    logic [N_ELECTRODES-2:0] shadow;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    start;
    logic                    accept;
    logic                    tick;
    logic                    phase;

    assign start  = enable_sr_out & ~req_d;
    assign accept = start && (state == ST_IDLE);

    sr_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clock (clock),
        .rst   (rst),
        .clear (accept),
        .enable((state == ST_SHIFT) || (state == ST_LATCH)),
        .tick  (tick),
        .phase (phase)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_d     <= 1'b0;
            shadow    <= '0;
            bit_cnt   <= '0;
            sr_clk    <= 1'b0;
            sr_data   <= 1'b0;
            sr_latch  <= 1'b0;
            sr_busy   <= 1'b0;
            sr_finish <= 1'b0;
        end else begin
            req_d <= enable_sr_out;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shadow  <= elec_config[N_ELECTRODES-2:0];
                        bit_cnt <= '0;
                        sr_data <= elec_config[N_ELECTRODES-1];
                        sr_clk  <= 1'b0;
                        sr_busy <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            sr_clk <= 1'b1;
                        end else begin
                            // falling-phase wrap: advance to the next bit
                            sr_clk <= 1'b0;
                            shadow <= shadow << 1;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt  <= '0;
                                sr_data  <= 1'b0;
                                sr_latch <= 1'b1;
                                state    <= ST_LATCH;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                sr_data <= shadow[N_ELECTRODES-2];
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        sr_latch  <= 1'b0;
                        sr_busy   <= 1'b0;
                        sr_finish <= 1'b1;
                        state     <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    sr_finish <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elec_sr_loader.sv
// tb/tb_elec_sr_loader.sv - directed bench for elec_sr_loader (N=8/CLK_DIV=2 and N=128/CLK_DIV=1)
module tb_elec_sr_loader;

    logic         clock;
    logic         rst;
    logic         en8;
    logic [7:0]   cfg8;
    logic         sr_clk8, sr_data8, sr_latch8, sr_busy8, sr_finish8;
    logic         en128;
    logic [127:0] cfg128;
    logic         sr_clk128, sr_data128, sr_latch128, sr_busy128, sr_finish128;

    int n_vec = 0;
    int n_err = 0;

    elec_sr_loader #(.N_ELECTRODES(8), .CLK_DIV(2)) dut8 (
        .clock        (clock),
        .rst          (rst),
        .enable_sr_out(en8),
        .elec_config  (cfg8),
        .sr_clk       (sr_clk8),
        .sr_data      (sr_data8),
        .sr_latch     (sr_latch8),
        .sr_busy      (sr_busy8),
        .sr_finish    (sr_finish8)
    );

    elec_sr_loader #(.N_ELECTRODES(128), .CLK_DIV(1)) dut128 (
        .clock        (clock),
        .rst          (rst),
        .enable_sr_out(en128),
        .elec_config  (cfg128),
        .sr_clk       (sr_clk128),
        .sr_data      (sr_data128),
        .sr_latch     (sr_latch128),
        .sr_busy      (sr_busy128),
        .sr_finish    (sr_finish128)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start a load at the current negedge (cycle 0) and observe cycles 1..ncyc.
    task automatic run8(input logic [7:0] cfg, input int ncyc, input int drop_at, input int raise_at,
                        input int cfg_at, input logic [7:0] cfg_new,
                        output logic [31:0] word, output int edges, output int fin_cnt,
                        output int fin1, output int fin2, output int lat_cnt, output int lat1,
                        output logic lat_bad, output logic busy_c1, output logic busy_fin);
        logic prev;
        prev = 1'b0; word = '0; edges = 0; fin_cnt = 0; fin1 = 0; fin2 = 0;
        lat_cnt = 0; lat1 = 0; lat_bad = 1'b0; busy_c1 = 1'b0; busy_fin = 1'b1;
        cfg8 = cfg;
        en8  = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock);
            if (sr_clk8 && !prev) begin
                word = {word[30:0], sr_data8};
                edges++;
            end
            prev = sr_clk8;
            if (k == 1) busy_c1 = sr_busy8;
            if (sr_finish8) begin
                fin_cnt++;
                if (fin_cnt == 1) begin
                    fin1 = k;
                    busy_fin = sr_busy8;
                end
                if (fin_cnt == 2) fin2 = k;
            end
            if (sr_latch8) begin
                lat_cnt++;
                if (lat1 == 0) lat1 = k;
                lat_bad = lat_bad | sr_data8 | sr_clk8;
            end
            if (k == drop_at) en8 = 1'b0;
            if (k == raise_at) en8 = 1'b1;
            if (k == cfg_at) cfg8 = cfg_new;
        end
        en8 = 1'b0;
        @(negedge clock);
    endtask

    task automatic run128(input logic [127:0] cfg, input int ncyc,
                          output logic [127:0] word, output int edges, output int fin_cnt,
                          output int fin1, output int lat_cnt, output int lat1);
        logic prev;
        prev = 1'b0; word = '0; edges = 0; fin_cnt = 0; fin1 = 0; lat_cnt = 0; lat1 = 0;
        cfg128 = cfg;
        en128  = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock);
            if (sr_clk128 && !prev) begin
                word = {word[126:0], sr_data128};
                edges++;
            end
            prev = sr_clk128;
            if (sr_finish128) begin
                fin_cnt++;
                if (fin1 == 0) fin1 = k;
            end
            if (sr_latch128) begin
                lat_cnt++;
                if (lat1 == 0) lat1 = k;
            end
            if (k == 2) en128 = 1'b0;
        end
        @(negedge clock);
    endtask

    typedef struct {
        logic [7:0] cfg;
        int         drop_at;
        int         raise_at;
        int         cfg_at;
        logic [7:0] cfg_new;
        logic [7:0] exp_word;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0]  w;
        logic [127:0] w128;
        logic [127:0] c128;
        int           edges, fin_cnt, fin1, fin2, lat_cnt, lat1;
        logic         lat_bad, busy_c1, busy_fin;
        int           seen_lat, seen_fin;

        vecs[0] = '{8'hA5, 2, 0, 0, 8'h00, 8'hA5};
        vecs[1] = '{8'hFF, 2, 0, 3, 8'h00, 8'hFF};
        vecs[2] = '{8'h3C, 0, 0, 0, 8'h00, 8'h3C};
        vecs[3] = '{8'h81, 7, 10, 0, 8'h00, 8'h81};
        vecs[4] = '{8'h00, 2, 0, 0, 8'hFF, 8'h00};
        vecs[5] = '{8'h5A, 2, 0, 1, 8'hA5, 8'h5A};

        rst = 1'b1; en8 = 1'b0; cfg8 = '0; en128 = 1'b0; cfg128 = '0;
        repeat (3) @(negedge clock);
        chk("reset_outputs_n8", {sr_clk8, sr_data8, sr_latch8, sr_busy8, sr_finish8}, 5'b0);
        chk("reset_outputs_n128", {sr_clk128, sr_data128, sr_latch128, sr_busy128, sr_finish128}, 5'b0);
        rst = 1'b0;

        // First vector starts on the first cycle after reset release.
        foreach (vecs[i]) begin
            run8(vecs[i].cfg, 50, vecs[i].drop_at, vecs[i].raise_at, vecs[i].cfg_at, vecs[i].cfg_new,
                 w, edges, fin_cnt, fin1, fin2, lat_cnt, lat1, lat_bad, busy_c1, busy_fin);
            chk($sformatf("v%0d_bits", i), w[7:0], vecs[i].exp_word);
            chk($sformatf("v%0d_clk_edges", i), edges, 8);
            chk($sformatf("v%0d_finish_count", i), fin_cnt, 1);
            chk($sformatf("v%0d_finish_cycle", i), fin1, 35);
            chk($sformatf("v%0d_latch_cycles", i), lat_cnt, 2);
            chk($sformatf("v%0d_latch_first", i), lat1, 33);
            chk($sformatf("v%0d_latch_clk_data_low", i), lat_bad, 1'b0);
            chk($sformatf("v%0d_busy_cycle1", i), busy_c1, 1'b1);
            chk($sformatf("v%0d_busy_at_finish", i), busy_fin, 1'b0);
        end

        // Re-raise in the idle cycle after FINISH: second load with a new word.
        run8(8'hA5, 80, 5, 36, 36, 8'h3C, w, edges, fin_cnt, fin1, fin2, lat_cnt, lat1,
             lat_bad, busy_c1, busy_fin);
        chk("b2b_bits", w[15:0], 16'hA53C);
        chk("b2b_clk_edges", edges, 16);
        chk("b2b_finish_count", fin_cnt, 2);
        chk("b2b_finish1", fin1, 35);
        chk("b2b_finish2", fin2, 71);
        chk("b2b_latch_cycles", lat_cnt, 4);

        // Rising edge while in FINISH is dropped, not queued.
        run8(8'hA5, 80, 5, 35, 0, 8'h00, w, edges, fin_cnt, fin1, fin2, lat_cnt, lat1,
             lat_bad, busy_c1, busy_fin);
        chk("finish_ignore_count", fin_cnt, 1);
        chk("finish_ignore_edges", edges, 8);

        c128 = '0;
        c128[127] = 1'b1;
        c128[0]   = 1'b1;
        run128(c128, 300, w128, edges, fin_cnt, fin1, lat_cnt, lat1);
        chk("n128_ends_bits", w128, c128);
        chk("n128_ends_edges", edges, 128);
        chk("n128_ends_finish_cycle", fin1, 258);
        chk("n128_ends_finish_count", fin_cnt, 1);
        chk("n128_ends_latch_cycles", lat_cnt, 1);
        chk("n128_ends_latch_first", lat1, 257);

        c128 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        run128(c128, 300, w128, edges, fin_cnt, fin1, lat_cnt, lat1);
        chk("n128_pattern_bits", w128, c128);
        chk("n128_pattern_finish_cycle", fin1, 258);

        // Reset at cycle 12 of an 8'hA5 load: bit 5 (=1) is in its high sr_clk half.
        seen_lat = 0; seen_fin = 0;
        cfg8 = 8'hA5;
        en8  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (sr_latch8) seen_lat++;
            if (sr_finish8) seen_fin++;
        end
        chk("pre_reset_clk_data_busy", {sr_clk8, sr_data8, sr_busy8}, 3'b111);
        rst = 1'b1;
        en8 = 1'b0;
        #1;
        chk("mid_reset_clk_data_busy", {sr_clk8, sr_data8, sr_busy8}, 3'b000);
        @(negedge clock);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (sr_latch8) seen_lat++;
            if (sr_finish8) seen_fin++;
        end
        chk("abort_no_latch", seen_lat, 0);
        chk("abort_no_finish", seen_fin, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
